// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: host program loader and sequential fetch sequencer
// driving the CLK-side port of a 16x13 synchronous instruction memory.
module instr_fetch_unit #(
   parameter int            AW      = 4,
   parameter int            DW      = 13,
   parameter logic [AW-1:0] BOOT_PC = '0
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          LOAD_EN,
   input  logic          LOAD_VALID,
   input  logic [DW-1:0] LOAD_DATA,
   output logic          LOAD_FULL,
   input  logic          START,
   input  logic          STOP,
   input  logic          STALL,
   input  logic          REDIRECT,
   input  logic [AW-1:0] REDIRECT_PC,
   output logic          IM_WR,
   output logic [AW-1:0] IM_A,
   output logic [DW-1:0] IM_D,
   input  logic [DW-1:0] IM_Q,
   output logic [DW-1:0] INSTR,
   output logic [AW-1:0] INSTR_PC,
   output logic          INSTR_VALID
);
   typedef enum logic [1:0] {IDLE, LOAD, PRIME, FETCH} state_t;
   state_t        state, nxt;
   logic [AW-1:0] cur_pc, nxt_pc;
   logic [AW:0]   load_cnt, nxt_cnt;
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         state    <= IDLE;
         cur_pc   <= '0;
         load_cnt <= '0;
      end else begin
         state    <= nxt;
         cur_pc   <= nxt_pc;
         load_cnt <= nxt_cnt;
      end
   // load_cnt MSB set means all 2**AW words written; it saturates there
   always_comb begin
      nxt         = state;
      nxt_pc      = cur_pc;
      nxt_cnt     = load_cnt;
      IM_WR       = 1'b0;
      IM_A        = '0;
      IM_D        = '0;
      INSTR       = '0;
      INSTR_PC    = '0;
      INSTR_VALID = 1'b0;
      LOAD_FULL   = 1'b0;
      case (state)
         IDLE: begin
            if (LOAD_EN) begin
               nxt     = LOAD;
               nxt_cnt = '0;
            end else if (START) nxt = PRIME;
         end
         LOAD: begin
            IM_A      = load_cnt[AW-1:0];
            IM_D      = LOAD_DATA;
            LOAD_FULL = load_cnt[AW];
            IM_WR     = LOAD_VALID & ~load_cnt[AW];
            nxt_cnt   = load_cnt + {{AW{1'b0}}, IM_WR};
            nxt       = LOAD_EN ? LOAD : IDLE;
         end
         PRIME: begin
            IM_A   = BOOT_PC;
            nxt_pc = BOOT_PC;
            nxt    = FETCH;
         end
         FETCH: begin
            INSTR_VALID = 1'b1;
            INSTR       = IM_Q;
            INSTR_PC    = cur_pc;
            // address issued now is what Q shows next cycle, so redirect costs no bubble
            IM_A   = STALL ? cur_pc : REDIRECT ? REDIRECT_PC : cur_pc + 1'b1;
            nxt_pc = IM_A;
            nxt    = STOP ? IDLE : FETCH;
         end
      endcase
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench with a behavioural memory and
// reference model; directed test plan followed by randomized traffic.
module tb_instr_fetch_unit;
   localparam logic [3:0] BOOT = 4'd0;
   logic        CLK = 1'b0, RST_N = 1'b0;
   logic        LOAD_EN = 0, LOAD_VALID = 0, START = 0, STOP = 0, STALL = 0, REDIRECT = 0;
   logic [12:0] LOAD_DATA = '0;
   logic [3:0]  REDIRECT_PC = '0;
   logic        LOAD_FULL, IM_WR, INSTR_VALID;
   logic [3:0]  IM_A, INSTR_PC;
   logic [12:0] IM_D, INSTR;
   logic [12:0] IM_Q = '0;
   logic [12:0] mem [16];
   always #5 CLK = ~CLK;

   instr_fetch_unit #(.AW(4), .DW(13), .BOOT_PC(BOOT)) dut (
      .CLK(CLK), .RST_N(RST_N), .LOAD_EN(LOAD_EN), .LOAD_VALID(LOAD_VALID),
      .LOAD_DATA(LOAD_DATA), .LOAD_FULL(LOAD_FULL), .START(START), .STOP(STOP),
      .STALL(STALL), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .IM_WR(IM_WR),
      .IM_A(IM_A), .IM_D(IM_D), .IM_Q(IM_Q), .INSTR(INSTR), .INSTR_PC(INSTR_PC),
      .INSTR_VALID(INSTR_VALID)
   );

   always @(posedge CLK) begin
      if (IM_WR) mem[IM_A] <= IM_D;
      IM_Q <= mem[IM_A];
   end

   typedef struct packed {logic [3:0] a; logic [12:0] d;} ent_t;
   ent_t wq[$], fq[$];
   int n_chk = 0, n_fail = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // monitor: pops expected writes / fetched instructions as the DUT presents them
   ent_t e;
   always @(negedge CLK) if (RST_N) begin
      if (IM_WR) begin
         if (wq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL write: unexpected IM_WR A=%0d D=%0h at %0t", IM_A, IM_D, $time);
         end else begin
            e = wq.pop_front();
            chk("write_addr", 32'(IM_A), 32'(e.a));
            chk("write_data", 32'(IM_D), 32'(e.d));
         end
      end else if (wq.size() != 0) begin
         e = wq.pop_front();
         n_chk++; n_fail++;
         $display("FAIL write: missing IM_WR, expected A=%0d D=%0h at %0t", e.a, e.d, $time);
      end
      if (INSTR_VALID) begin
         if (fq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL fetch: unexpected INSTR_VALID pc=%0d at %0t", INSTR_PC, $time);
         end else begin
            e = fq.pop_front();
            chk("instr_pc", 32'(INSTR_PC), 32'(e.a));
            chk("instr", 32'(INSTR), 32'(e.d));
         end
      end else if (fq.size() != 0) begin
         e = fq.pop_front();
         n_chk++; n_fail++;
         $display("FAIL fetch: INSTR_VALID low, expected pc=%0d at %0t", e.a, $time);
      end
   end

   // reference model: mode 0 idle, 1 load, 2 prime, 3 fetch
   int          ms = 0, mcnt = 0;
   logic [3:0]  mpc = '0;
   logic [12:0] rm [16];

   task automatic cyc();
      logic [3:0] ea;
      ea = '0;
      if (ms == 1) ea = 4'(mcnt);
      else if (ms == 2) ea = BOOT;
      else if (ms == 3) ea = STALL ? mpc : REDIRECT ? REDIRECT_PC : 4'(mpc + 1);
      #1;
      chk("im_a", 32'(IM_A), 32'(ea));
      chk("im_d", 32'(IM_D), (ms == 1) ? 32'(LOAD_DATA) : 32'd0);
      chk("load_full", 32'(LOAD_FULL), 32'(ms == 1 && mcnt == 16));
      if (ms != 3) begin
         chk("instr_off", 32'(INSTR), 32'd0);
         chk("instr_pc_off", 32'(INSTR_PC), 32'd0);
      end
      case (ms)
         0: if (LOAD_EN) begin ms = 1; mcnt = 0; end else if (START) ms = 2;
         1: begin
            if (LOAD_VALID && mcnt < 16) begin
               wq.push_back('{a: 4'(mcnt), d: LOAD_DATA});
               rm[mcnt] = LOAD_DATA;
               mcnt++;
            end
            if (!LOAD_EN) ms = 0;
         end
         2: begin mpc = BOOT; ms = 3; end
         default: begin
            fq.push_back('{a: mpc, d: rm[mpc]});
            if (STOP) ms = 0; else mpc = ea;
         end
      endcase
      @(posedge CLK); #1;
   endtask

   task automatic clr();
      LOAD_EN = 0; LOAD_VALID = 0; START = 0; STOP = 0; STALL = 0; REDIRECT = 0;
   endtask

   task automatic async_reset();
      #2 RST_N = 1'b0;
      #1;
      chk("rst_im_wr", 32'(IM_WR), 32'd0);
      chk("rst_im_a", 32'(IM_A), 32'd0);
      chk("rst_im_d", 32'(IM_D), 32'd0);
      chk("rst_instr", 32'(INSTR), 32'd0);
      chk("rst_instr_pc", 32'(INSTR_PC), 32'd0);
      chk("rst_valid", 32'(INSTR_VALID), 32'd0);
      chk("rst_load_full", 32'(LOAD_FULL), 32'd0);
      ms = 0; mcnt = 0; mpc = '0;
      wq.delete(); fq.delete();
      clr();
      @(negedge CLK); #1 RST_N = 1'b1;
      @(posedge CLK); #1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin mem[i] = '0; rm[i] = '0; end
      @(posedge CLK); #1;
      async_reset();
      // full load plus one ignored word
      LOAD_EN = 1; cyc();
      for (int i = 0; i < 17; i++) begin
         LOAD_VALID = 1; LOAD_DATA = (i == 16) ? 13'h1FFF : 13'(13'h0A00 + i);
         cyc();
      end
      LOAD_VALID = 0; cyc();
      LOAD_EN = 0; cyc();
      cyc();
      // sequential fetch with wrap
      START = 1; cyc();
      START = 0; cyc();
      for (int i = 0; i < 20; i++) cyc();
      REDIRECT = 1; REDIRECT_PC = 4'd11; cyc();
      REDIRECT = 0; cyc();
      REDIRECT = 1; REDIRECT_PC = 4'd5; cyc();
      REDIRECT = 0; STALL = 1; cyc();
      REDIRECT = 1; REDIRECT_PC = 4'd9; cyc();
      REDIRECT = 0; cyc();
      STALL = 0; cyc();
      cyc();
      STALL = 1; STOP = 1; cyc();
      clr(); cyc(); cyc();
      START = 1; cyc();
      START = 0; for (int i = 0; i < 4; i++) cyc();
      STOP = 1; cyc();
      STOP = 0; cyc();
      // reset mid-load after 5 words
      LOAD_EN = 1; cyc();
      for (int i = 0; i < 5; i++) begin
         LOAD_VALID = 1; LOAD_DATA = 13'(13'h1500 + i); cyc();
      end
      LOAD_DATA = 13'h1505;
      async_reset();
      START = 1; cyc();
      START = 0; for (int i = 0; i < 18; i++) cyc();
      STOP = 1; cyc();
      clr(); cyc();
      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 15) == 0) LOAD_EN = ~LOAD_EN;
         LOAD_VALID  = $urandom_range(0, 3) != 0;
         LOAD_DATA   = 13'($urandom);
         START       = $urandom_range(0, 3) == 0;
         STOP        = $urandom_range(0, 19) == 0;
         STALL       = $urandom_range(0, 3) == 0;
         REDIRECT    = $urandom_range(0, 3) == 0;
         REDIRECT_PC = 4'($urandom);
         cyc();
      end
      clr(); cyc(); cyc();
      @(posedge CLK); #1;
      chk("write_queue_drained", 32'(wq.size()), 32'd0);
      chk("fetch_queue_drained", 32'(fq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
